// File: rtl/vc_grant_decoder_pkg.sv
// -----------------------------------------------------------------------------
// vc_grant_decoder_pkg
// Shared definitions for the VC grant decoder:
//   - default VC count and binary index width
//   - FSM state encoding (IDLE / LOCKED)
//   - sticky error codes reported on err when VC_GRANT_ERR_EN is defined
// -----------------------------------------------------------------------------
package vc_grant_decoder_pkg;

  localparam int NO_VC_DEF = 15;
  localparam int IDX_W_DEF = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,  // no error seen since reset
    ERR_RANGE = 2'b01,  // request index >= number of VCs
    ERR_ALLOW = 2'b10,  // request for a VC whose allow bit was clear
    ERR_NOGNT = 2'b11   // flit reported while no VC was locked
  } err_e;

endpackage

// File: rtl/vc_grant_decoder_onehot_dec.sv
// -----------------------------------------------------------------------------
// vc_grant_decoder_onehot_dec
// Purely combinational binary index -> one-hot decoder with a range flag.
// Ports:
//   idx      in   idx_w   binary VC index
//   onehot   out  no_vc   one-hot decode; all-zero when idx is out of range
//   in_range out  1       idx < no_vc
// -----------------------------------------------------------------------------
module vc_grant_decoder_onehot_dec
  import vc_grant_decoder_pkg::*;
#(
  parameter int no_vc = NO_VC_DEF,
  parameter int idx_w = IDX_W_DEF
) (
  input  logic [idx_w-1:0] idx,
  output logic [no_vc-1:0] onehot,
  output logic             in_range
);

  // Each bit compares against its own constant, so an out-of-range index
  // naturally decodes to all-zero and the result can never be multi-hot.
  for (genvar gi = 0; gi < no_vc; gi++) begin : g_dec
    assign onehot[gi] = (idx == idx_w'(gi));
  end

  assign in_range = (int'(idx) < no_vc);

endmodule

// File: rtl/vc_grant_decoder.sv
// -----------------------------------------------------------------------------
// vc_grant_decoder
// Turns the VC arbiter's binary index into a one-hot grant that is locked from
// head flit to tail flit. A new request may be accepted in the tail cycle, in
// which case the grant switches VCs without an idle bubble.
// Optional feature macro: VC_GRANT_ERR_EN (sticky first-error code on err).
// Ports:
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous active-high reset
//   req_valid   in   1      req_idx valid this cycle
//   req_idx     in   idx    requested VC index
//   vc_allow    in   no_vc  per-VC permission mask, sampled at accept only
//   req_ready   out  1      decoder can take a request this cycle (comb)
//   flit_valid  in   1      a flit moved on the granted VC
//   flit_tail   in   1      that flit is the tail (qualified by flit_valid)
//   grant       out  no_vc  registered one-hot grant, zero when idle
//   grant_valid out  1      registered, high while a VC is locked
//   pkt_flits   out  cnt_w  saturating flit count of current/last packet
//   err         out  2      sticky error code (2'b00 when feature disabled)
// -----------------------------------------------------------------------------
module vc_grant_decoder
  import vc_grant_decoder_pkg::*;
#(
  parameter int no_vc                   = NO_VC_DEF,
  parameter int floorplusone_log2_no_vc = IDX_W_DEF,
  parameter int cnt_w                   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  input  logic [floorplusone_log2_no_vc-1:0] req_idx,
  input  logic [no_vc-1:0]                   vc_allow,
  output logic                               req_ready,
  input  logic                               flit_valid,
  input  logic                               flit_tail,
  output logic [no_vc-1:0]                   grant,
  output logic                               grant_valid,
  output logic [cnt_w-1:0]                   pkt_flits,
  output logic [1:0]                         err
);

  state_e             state_q, state_d;
  logic [no_vc-1:0]   grant_q, grant_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;

  logic [no_vc-1:0]   dec_onehot;
  logic               dec_in_range;
  logic               allow_hit;
  logic               accept;

  vc_grant_decoder_onehot_dec #(
    .no_vc (no_vc),
    .idx_w (floorplusone_log2_no_vc)
  ) u_dec (
    .idx      (req_idx),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  // Masking the decode avoids indexing vc_allow with an out-of-range index.
  assign allow_hit = |(vc_allow & dec_onehot);

  // Ready in the tail cycle lets the next packet start back-to-back.
  assign req_ready = (state_q == ST_IDLE) | (flit_valid & flit_tail);
  assign accept    = req_valid & req_ready & dec_in_range & allow_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ST_LOCKED;
      grant_d = dec_onehot;
      cnt_d   = '0;
    end else if (state_q == ST_LOCKED) begin
      if (flit_valid && (cnt_q != {cnt_w{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (flit_valid && flit_tail) begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == ST_LOCKED);
  assign pkt_flits   = cnt_q;

`ifdef VC_GRANT_ERR_EN
  err_e err_q, err_d;

  // Only the first error is kept; within one cycle range beats allow beats
  // the stray-flit case.
  always_comb begin
    err_d = err_q;
    if (err_q == ERR_NONE) begin
      if (req_valid && req_ready && !dec_in_range) begin
        err_d = ERR_RANGE;
      end else if (req_valid && req_ready && !allow_hit) begin
        err_d = ERR_ALLOW;
      end else if ((state_q == ST_IDLE) && flit_valid) begin
        err_d = ERR_NOGNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= ERR_NONE;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

endmodule
